// File: rtl/wb_arbiter_pkg.sv
// Shared hart definitions for the writeback path: data/index widths,
// the writeback record carried through the mul/div buffer, and the
// source selector used by the arbiter.
package wb_arbiter_pkg;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]  d;
    logic [REG_W-1:0] rd;
  } wb_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LD   = 2'd2,
    SRC_MD   = 2'd3
  } src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: the three result sources on one side and the register-file
// write port plus pipeline status on the other.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic [XLEN-1:0]  alu_d;
  logic [REG_W-1:0] alu_rd;
  logic             alu_vld;

  logic [XLEN-1:0]  ld_d;
  logic [REG_W-1:0] ld_rd;
  logic             ld_vld;
  logic             ld_rdy;

  logic [XLEN-1:0]  md_d;
  logic [REG_W-1:0] md_rd;
  logic             md_vld;
  logic             md_rdy;

  logic [XLEN-1:0]  d;
  logic [REG_W-1:0] rd;
  logic             wr;
  logic             stall;
  logic             busy;

  modport master (
    output alu_d, alu_rd, alu_vld,
    output ld_d, ld_rd, ld_vld,
    output md_d, md_rd, md_vld,
    input  ld_rdy, md_rdy,
    input  d, rd, wr, stall, busy
  );

  modport slave (
    input  alu_d, alu_rd, alu_vld,
    input  ld_d, ld_rd, ld_vld,
    input  md_d, md_rd, md_vld,
    output ld_rdy, md_rdy,
    output d, rd, wr, stall, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding mul/div writeback records until the
// arbiter finds a free write slot. DEPTH must be a power of two so the
// pointers wrap naturally.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_t              push_data,
  input  logic             pop,
  output wb_t              pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_t              mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // storage write; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // pointer and occupancy tracking; push+pop together keeps count steady
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign pop_data = mem[head];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU / load / buffered mul-div result per
// cycle in fixed priority and registers it onto the register-file write
// port. A starvation counter on the mul/div head raises stall so the
// pipeline eventually frees a slot.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int MD_DEPTH   = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);

  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam int CNT_W  = $clog2(MD_DEPTH + 1);

  src_e             sel;
  wb_t              wb_sel;
  wb_t              md_in;
  wb_t              md_head;
  logic             md_push;
  logic             md_pop;
  logic             md_full;
  logic             md_empty;
  logic [CNT_W-1:0] md_count;
  logic             ld_rdy;
  logic             md_rdy;
  logic             take;

  logic [WAIT_W-1:0] wait_cnt;
  logic [XLEN-1:0]   d_p1;
  logic [REG_W-1:0]  rd_p1;
  logic              wr_p1;
  logic              stall_p1;

  // Handshakes: the FIFO's readiness ignores a same-cycle pop on purpose,
  // keeping md_rdy off the selection path.
  assign ld_rdy  = !rst && !bus.alu_vld;
  assign md_rdy  = !rst && !md_full;
  assign md_push = bus.md_vld && md_rdy;
  assign md_in   = '{d: bus.md_d, rd: bus.md_rd};

  wb_fifo #(
    .DEPTH (MD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (md_push),
    .push_data (md_in),
    .pop       (md_pop),
    .pop_data  (md_head),
    .full      (md_full),
    .empty     (md_empty),
    .count     (md_count)
  );

  // fixed-priority selection: ALU, then load, then FIFO head (never a bypass)
  always_comb begin
    sel    = SRC_NONE;
    wb_sel = '0;
    if (bus.alu_vld) begin
      sel    = SRC_ALU;
      wb_sel = '{d: bus.alu_d, rd: bus.alu_rd};
    end else if (bus.ld_vld && ld_rdy) begin
      sel    = SRC_LD;
      wb_sel = '{d: bus.ld_d, rd: bus.ld_rd};
    end else if (!md_empty && !rst) begin
      sel    = SRC_MD;
      wb_sel = md_head;
    end
  end

  assign md_pop = (sel == SRC_MD);
  assign take   = (sel != SRC_NONE) && (wb_sel.rd != '0);

  // ---- stage p1: register-file write port; x0 results are dropped and
  // leave d/rd holding the last real write
  always_ff @(posedge clk) begin
    if (rst) begin
      d_p1  <= '0;
      rd_p1 <= '0;
      wr_p1 <= 1'b0;
    end else begin
      wr_p1 <= take;
      if (take) begin
        d_p1  <= wb_sel.d;
        rd_p1 <= wb_sel.rd;
      end
    end
  end

  // starvation tracking of the FIFO head; stall follows the saturated count
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      stall_p1 <= 1'b0;
    end else begin
      stall_p1 <= (wait_cnt == WAIT_W'(STARVE_LIM));
      if (md_pop || md_empty)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(STARVE_LIM))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign bus.ld_rdy = ld_rdy;
  assign bus.md_rdy = md_rdy;
  assign bus.d      = d_p1;
  assign bus.rd     = rd_p1;
  assign bus.wr     = wr_p1;
  assign bus.stall  = stall_p1;
  assign bus.busy   = (md_count != '0) || wr_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic. A
// queue-based reference model predicts each register-file write and the
// status outputs; a monitor process checks the DUT after every clock edge.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int MD_DEPTH   = 2;
  localparam int STARVE_LIM = 8;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  rd;
    int          tag;
  } want_t;

  logic clk = 1'b0;
  logic rst;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .MD_DEPTH   (MD_DEPTH),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  want_t       sb[$];
  wb_t         mq[$];
  int          m_wait  = 0;
  bit          m_stall = 1'b0;
  bit          m_wr    = 1'b0;
  bit          m_busy  = 1'b0;
  logic [63:0] m_d     = '0;
  logic [4:0]  m_rd    = '0;
  int          edge_n  = 0;
  int          mon_n   = 0;
  bit          mon_en  = 1'b0;
  bit          ld_acc  = 1'b0;
  bit          ld_pend = 1'b0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, mon_n);
    end
  endtask

  task automatic idle();
    bus.alu_vld = 1'b0;
    bus.ld_vld  = 1'b0;
    bus.md_vld  = 1'b0;
  endtask

  // One clock cycle: check the combinational handshakes, advance the
  // reference model with the inputs currently on the bus, then clock.
  task automatic step();
    int  sz;
    bit  has;
    bit  popped;
    bit  next_stall;
    wb_t w;
    #1;
    sz = mq.size();
    chk("ld_rdy", 64'(bus.ld_rdy), 64'(!rst && !bus.alu_vld));
    chk("md_rdy", 64'(bus.md_rdy), 64'(!rst && sz < MD_DEPTH));
    ld_acc = 1'b0;
    if (rst) begin
      mq.delete();
      m_wait  = 0;
      m_stall = 1'b0;
      m_wr    = 1'b0;
      m_d     = '0;
      m_rd    = '0;
    end else begin
      has    = 1'b1;
      popped = 1'b0;
      w      = '0;
      if (bus.alu_vld) begin
        w.d  = bus.alu_d;
        w.rd = bus.alu_rd;
      end else if (bus.ld_vld) begin
        w.d    = bus.ld_d;
        w.rd   = bus.ld_rd;
        ld_acc = 1'b1;
      end else if (sz > 0) begin
        w      = mq.pop_front();
        popped = 1'b1;
      end else begin
        has = 1'b0;
      end
      next_stall = (m_wait == STARVE_LIM);
      if (popped || sz == 0) m_wait = 0;
      else if (m_wait < STARVE_LIM) m_wait = m_wait + 1;
      if (bus.md_vld && sz < MD_DEPTH) mq.push_back('{d: bus.md_d, rd: bus.md_rd});
      m_stall = next_stall;
      m_wr    = has && (w.rd != 5'd0);
      if (m_wr) begin
        m_d  = w.d;
        m_rd = w.rd;
        sb.push_back('{w.d, w.rd, edge_n});
      end
    end
    m_busy = (mq.size() != 0) || m_wr;
    mon_en = 1'b1;
    edge_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // monitor: compares the registered outputs after each edge with the model
  always @(posedge clk) begin
    want_t e;
    #1;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].tag == mon_n) begin
        e = sb.pop_front();
        chk("wr", 64'(bus.wr), 64'd1);
        chk("wr_d", bus.d, e.d);
        chk("wr_rd", 64'(bus.rd), 64'(e.rd));
      end else begin
        chk("wr_idle", 64'(bus.wr), 64'd0);
      end
      chk("d_hold", bus.d, m_d);
      chk("rd_hold", 64'(bus.rd), 64'(m_rd));
      chk("stall", 64'(bus.stall), 64'(m_stall));
      chk("busy", 64'(bus.busy), 64'(m_busy));
      mon_n++;
    end
  end

  initial begin
    rst        = 1'b1;
    bus.alu_d  = '0;
    bus.alu_rd = '0;
    bus.ld_d   = '0;
    bus.ld_rd  = '0;
    bus.md_d   = '0;
    bus.md_rd  = '0;
    idle();
    step();
    step();
    rst = 1'b0;

    // plain ALU writeback
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd5; bus.alu_d = 64'h1234;
    step();
    chk("t1_wr", 64'(bus.wr), 64'd1);
    chk("t1_rd", 64'(bus.rd), 64'd5);
    chk("t1_d", bus.d, 64'h1234);
    idle();
    step();

    // ALU and load collide: ALU first, load one cycle later
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd3; bus.alu_d = 64'h33;
    bus.ld_vld  = 1'b1; bus.ld_rd  = 5'd7; bus.ld_d  = 64'hAA;
    step();
    chk("t2_alu_rd", 64'(bus.rd), 64'd3);
    bus.alu_vld = 1'b0;
    step();
    chk("t2_ld_rd", 64'(bus.rd), 64'd7);
    chk("t2_ld_d", bus.d, 64'hAA);
    idle();
    step();

    // fill the FIFO behind x0 ALU traffic, then drain in push order
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd0; bus.alu_d = 64'hDEAD;
    bus.md_vld  = 1'b1; bus.md_rd  = 5'd10; bus.md_d = 64'hA0;
    step();
    bus.md_rd = 5'd11; bus.md_d = 64'hA1;
    step();
    bus.md_rd = 5'd12; bus.md_d = 64'hA2;
    #1 chk("t3_md_rdy_full", 64'(bus.md_rdy), 64'd0);
    step();
    idle();
    step();
    chk("t3_first_rd", 64'(bus.rd), 64'd10);
    chk("t3_first_d", bus.d, 64'hA0);
    step();
    chk("t3_second_rd", 64'(bus.rd), 64'd11);
    step();

    // starvation: one entry behind continuous ALU results
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd1; bus.alu_d = 64'h0;
    bus.md_vld  = 1'b1; bus.md_rd  = 5'd20; bus.md_d = 64'hC0;
    step();
    bus.md_vld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus.alu_d = 64'(k);
      step();
    end
    chk("t4_stall_early", 64'(bus.stall), 64'd0);
    step();
    chk("t4_stall", 64'(bus.stall), 64'd1);
    step();
    step();
    bus.alu_vld = 1'b0;
    step();
    chk("t4_md_wr", 64'(bus.wr), 64'd1);
    chk("t4_md_rd", 64'(bus.rd), 64'd20);
    step();
    chk("t4_stall_clear", 64'(bus.stall), 64'd0);

    // load to x0 completes but writes nothing
    idle();
    bus.ld_vld = 1'b1; bus.ld_rd = 5'd0; bus.ld_d = 64'hFF;
    #1 chk("t5_ld_rdy", 64'(bus.ld_rdy), 64'd1);
    step();
    bus.ld_vld = 1'b0;
    chk("t5_wr", 64'(bus.wr), 64'd0);
    chk("t5_rd_hold", 64'(bus.rd), 64'd20);
    chk("t5_d_hold", bus.d, 64'hC0);

    // reset with a full FIFO and stall raised
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd0;
    bus.md_vld  = 1'b1; bus.md_rd  = 5'd21; bus.md_d = 64'hB1;
    step();
    bus.md_rd = 5'd22; bus.md_d = 64'hB2;
    step();
    bus.md_vld = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("t6_stall_before", 64'(bus.stall), 64'd1);
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_stall", 64'(bus.stall), 64'd0);
    chk("t6_md_rdy", 64'(bus.md_rdy), 64'd1);
    step();
    step();

    // random traffic honouring the load-hold and stall protocols
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      bus.alu_vld = !m_stall && ($urandom_range(0, 99) < ((i < 1500) ? 45 : 80));
      bus.alu_d   = {$urandom, $urandom};
      bus.alu_rd  = 5'($urandom);
      if (!ld_pend && $urandom_range(0, 99) < 35) begin
        ld_pend   = 1'b1;
        bus.ld_d  = {$urandom, $urandom};
        bus.ld_rd = 5'($urandom);
      end
      bus.ld_vld = ld_pend;
      bus.md_vld = ($urandom_range(0, 99) < 40);
      bus.md_d   = {$urandom, $urandom};
      bus.md_rd  = 5'($urandom);
      step();
      if (ld_acc) ld_pend = 1'b0;
    end

    rst = 1'b0;
    idle();
    for (int k = 0; k < 6; k++) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
